// File: rtl/btb_bimodal_predictor_pkg.sv
// Shared types and helpers for the BTB/bimodal branch predictor.
package btb_bimodal_predictor_pkg;

  localparam int unsigned XLEN      = 32;
  // Widest tag needed (NENTRIES=2); narrower tags are zero-extended into it.
  localparam int unsigned BTB_TAG_W = 30;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'b00;
  localparam ctr2_t CTR_WNT = 2'b01;
  localparam ctr2_t CTR_WT  = 2'b10;
  localparam ctr2_t CTR_ST  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      target;
    ctr2_t                ctr;
  } btb_entry_t;

  function automatic ctr2_t sat_update(ctr2_t ctr, logic taken);
    ctr2_t res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_ST) res = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btb_bimodal_predictor_sat_counter2.sv
// Next-state logic of a 2-bit saturating direction counter.
module btb_bimodal_predictor_sat_counter2
  import btb_bimodal_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_c_o
);

  assign ctr_c_o = sat_update(ctr2_t'(ctr_i), taken_i);

endmodule

// File: rtl/btb_bimodal_predictor.sv
// Direct-mapped BTB with 2-bit counters; same-cycle lookup, BTFN fallback on miss,
// one resolved update per cycle.
module btb_bimodal_predictor
  import btb_bimodal_predictor_pkg::*;
#(
  parameter int unsigned NENTRIES = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] current_pc,
  input  logic        is_branch,
  input  logic        is_rv32c,
  input  logic [12:0] imm_sb,
  input  logic [31:0] instr,
  input  logic        update_predictor,
  input  logic [31:0] pc_to_update,
  input  logic [31:0] update_addr,
  input  logic        branch_result,
  input  logic        prediction,
  input  logic        direction,
  output logic        predict_taken,
  output logic [31:0] target_addr
);

  localparam int unsigned IDX_BITS = $clog2(NENTRIES);
  localparam btb_entry_t  RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

  btb_entry_t btb_q [NENTRIES];

  logic [31:0] update_cnt_q, update_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX_BITS-1:0]  rd_idx, wr_idx;
  logic [BTB_TAG_W-1:0] rd_tag, wr_tag;
  btb_entry_t           rd_entry, wr_old, wr_entry_d;
  logic                 rd_hit, wr_hit;
  logic [31:0]          imm_sext;
  logic [1:0]           ctr_upd_c;

  // Halfword-granular index so RVC branches in the same word get separate entries.
  assign rd_idx   = current_pc[IDX_BITS:1];
  assign rd_tag   = BTB_TAG_W'(current_pc[31:IDX_BITS+1]);
  assign rd_entry = btb_q[rd_idx];
  assign rd_hit   = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign imm_sext = {{19{imm_sb[12]}}, imm_sb};

  always_comb begin
    predict_taken = 1'b0;
    target_addr   = current_pc + (is_rv32c ? 32'd2 : 32'd4);
    if (rd_hit) begin
      predict_taken = rd_entry.ctr[1];
      target_addr   = rd_entry.target;
    end else if (is_branch) begin
      predict_taken = imm_sb[12];
      target_addr   = current_pc + imm_sext;
    end
  end

  assign wr_idx = pc_to_update[IDX_BITS:1];
  assign wr_tag = BTB_TAG_W'(pc_to_update[31:IDX_BITS+1]);
  assign wr_old = btb_q[wr_idx];
  assign wr_hit = wr_old.valid && (wr_old.tag == wr_tag);

  btb_bimodal_predictor_sat_counter2 u_sat_counter2 (
    .ctr_i   (wr_old.ctr),
    .taken_i (branch_result),
    .ctr_c_o (ctr_upd_c)
  );

  // Train on a tag hit, otherwise allocate with a weak counter in the resolved direction.
  always_comb begin
    wr_entry_d        = RST_ENTRY;
    wr_entry_d.valid  = 1'b1;
    wr_entry_d.tag    = wr_tag;
    wr_entry_d.target = update_addr;
    wr_entry_d.ctr    = wr_hit ? ctr2_t'(ctr_upd_c) : (branch_result ? CTR_WT : CTR_WNT);
  end

  assign update_cnt_d     = (update_cnt_q == '1) ? update_cnt_q : update_cnt_q + 32'd1;
  assign mispredict_cnt_d = (mispredict_cnt_q == '1) ? mispredict_cnt_q : mispredict_cnt_q + 32'd1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NENTRIES; i++) begin
        btb_q[i] <= RST_ENTRY;
      end
      update_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (update_predictor) begin
      btb_q[wr_idx] <= wr_entry_d;
      update_cnt_q  <= update_cnt_d;
      if (prediction != branch_result) mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{instr, direction, current_pc[0], pc_to_update[0]};

endmodule

// File: tb/tb_btb_bimodal_predictor.sv
// Self-checking bench for btb_bimodal_predictor against a table-level reference model.
module tb_btb_bimodal_predictor;

  localparam int NENT = 64;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] current_pc;
  logic        is_branch;
  logic        is_rv32c;
  logic [12:0] imm_sb;
  logic [31:0] instr;
  logic        update_predictor;
  logic [31:0] pc_to_update;
  logic [31:0] update_addr;
  logic        branch_result;
  logic        prediction;
  logic        direction;
  logic        predict_taken;
  logic [31:0] target_addr;

  btb_bimodal_predictor #(.NENTRIES(NENT)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .current_pc       (current_pc),
    .is_branch        (is_branch),
    .is_rv32c         (is_rv32c),
    .imm_sb           (imm_sb),
    .instr            (instr),
    .update_predictor (update_predictor),
    .pc_to_update     (pc_to_update),
    .update_addr      (update_addr),
    .branch_result    (branch_result),
    .prediction       (prediction),
    .direction        (direction),
    .predict_taken    (predict_taken),
    .target_addr      (target_addr)
  );

  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: plain per-slot arrays, counter kept as an integer 0..3.
  bit          m_valid [NENT];
  int unsigned m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];
  int unsigned m_upd;
  int unsigned m_mis;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_upd = 0;
    m_mis = 0;
  endfunction

  function automatic void model_lookup(output logic pt, output logic [31:0] ta);
    int i;
    i = int'((current_pc / 2) % NENT);
    if (m_valid[i] && m_tag[i] == current_pc / (2 * NENT)) begin
      pt = (m_ctr[i] >= 2);
      ta = m_tgt[i];
    end else if (is_branch) begin
      pt = (imm_sb >= 13'h1000);
      ta = current_pc + 32'($signed(imm_sb));
    end else begin
      pt = 1'b0;
      ta = current_pc + (is_rv32c ? 32'd2 : 32'd4);
    end
  endfunction

  function automatic void model_update();
    int i;
    int unsigned t;
    if (!update_predictor) return;
    i = int'((pc_to_update / 2) % NENT);
    t = pc_to_update / (2 * NENT);
    if (m_valid[i] && m_tag[i] == t) begin
      m_tgt[i] = update_addr;
      if (branch_result) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      else               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end else begin
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_tgt[i]   = update_addr;
      m_ctr[i]   = branch_result ? 2 : 1;
    end
    m_upd++;
    if (prediction != branch_result) m_mis++;
  endfunction

  task automatic set_look(input logic [31:0] pc, input logic br, input logic c, input logic [12:0] imm);
    current_pc = pc;
    is_branch  = br;
    is_rv32c   = c;
    imm_sb     = imm;
    instr      = $urandom;
    direction  = 1'($urandom);
  endtask

  task automatic set_upd(input logic en, input logic [31:0] pc, input logic [31:0] addr,
                         input logic res, input logic pred);
    update_predictor = en;
    pc_to_update     = pc;
    update_addr      = addr;
    branch_result    = res;
    prediction       = pred;
  endtask

  // One clock: compare against the model on the falling edge, then advance the model.
  task automatic cycle(input bit pin = 1'b0, input logic ept = 1'b0,
                       input logic [31:0] eta = 32'h0, input string nm = "");
    logic        pt;
    logic [31:0] ta;
    @(negedge CLK);
    model_lookup(pt, ta);
    chk("model_predict_taken", 32'(predict_taken), 32'(pt));
    chk("model_target_addr", target_addr, ta);
    chk("model_update_cnt", dut.update_cnt_q, m_upd);
    chk("model_mispredict_cnt", dut.mispredict_cnt_q, m_mis);
    if (pin) begin
      chk({nm, "_predict_taken"}, 32'(predict_taken), 32'(ept));
      chk({nm, "_target_addr"}, target_addr, eta);
    end
    @(posedge CLK);
    if (nRST) model_update();
    #1;
  endtask

  // Assert reset between edges while an update may be pending; release after the edge.
  task automatic reset_mid();
    logic        pt;
    logic [31:0] ta;
    @(negedge CLK);
    model_lookup(pt, ta);
    chk("model_predict_taken", 32'(predict_taken), 32'(pt));
    chk("model_target_addr", target_addr, ta);
    #2 nRST = 1'b0;
    model_reset();
    @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  int unsigned mis_before;

  initial begin
    nRST = 1'b0;
    set_look(32'h0, 1'b0, 1'b0, 13'h0);
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Reset state and sequential fall-through
    set_look(32'h100, 1'b0, 1'b0, 13'h0);
    cycle(1'b1, 1'b0, 32'h104, "rst_seq");
    set_look(32'h100, 1'b0, 1'b1, 13'h0);
    cycle(1'b1, 1'b0, 32'h102, "rst_rvc");
    chk("rst_update_cnt", dut.update_cnt_q, 32'd0);

    // Allocate taken, then train up to strongly taken and saturate
    set_look(32'h300, 1'b0, 1'b0, 13'h0);
    set_upd(1'b1, 32'h100, 32'h80, 1'b1, 1'b0);
    cycle();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_look(32'h100, 1'b0, 1'b0, 13'h0);
    cycle(1'b1, 1'b1, 32'h80, "alloc_taken");
    chk("alloc_ctr", 32'(dut.btb_q[0].ctr), 32'd2);
    set_upd(1'b1, 32'h100, 32'h80, 1'b1, 1'b1);
    cycle();
    cycle();
    chk("ctr_sat_hi_a", 32'(dut.btb_q[0].ctr), 32'd3);
    cycle();
    chk("ctr_sat_hi_b", 32'(dut.btb_q[0].ctr), 32'd3);

    // Walk down to strongly not-taken
    set_upd(1'b1, 32'h100, 32'h80, 1'b0, 1'b1);
    cycle();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h80, "nt_after1");
    set_upd(1'b1, 32'h100, 32'h80, 1'b0, 1'b1);
    cycle();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h80, "nt_after2");
    chk("ctr_after2", 32'(dut.btb_q[0].ctr), 32'd1);
    set_upd(1'b1, 32'h100, 32'h80, 1'b0, 1'b0);
    cycle();
    cycle();
    chk("ctr_sat_lo_a", 32'(dut.btb_q[0].ctr), 32'd0);
    cycle();
    chk("ctr_sat_lo_b", 32'(dut.btb_q[0].ctr), 32'd0);
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Static BTFN on a miss
    set_look(32'h200, 1'b1, 1'b0, 13'h1FF0);
    cycle(1'b1, 1'b1, 32'h1F0, "btfn_back");
    set_look(32'h200, 1'b1, 1'b0, 13'h0010);
    cycle(1'b1, 1'b0, 32'h210, "btfn_fwd");

    // Aliasing replacement at index 0
    set_upd(1'b1, 32'h180, 32'h40, 1'b0, 1'b0);
    cycle();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_look(32'h100, 1'b0, 1'b0, 13'h0);
    cycle(1'b1, 1'b0, 32'h104, "alias_evicted");
    set_look(32'h180, 1'b1, 1'b0, 13'h1FF0);
    cycle(1'b1, 1'b0, 32'h40, "alias_new");
    chk("alias_ctr", 32'(dut.btb_q[0].ctr), 32'd1);

    // Same-cycle lookup and update, with a mispredict
    mis_before = dut.mispredict_cnt_q;
    set_look(32'h180, 1'b0, 1'b0, 13'h0);
    set_upd(1'b1, 32'h180, 32'h500, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h40, "same_cycle_old");
    chk("mispredict_delta", dut.mispredict_cnt_q - mis_before, 32'd1);
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h500, "same_cycle_new");

    // Reset coincident with an update
    set_upd(1'b1, 32'h180, 32'h900, 1'b1, 1'b0);
    reset_mid();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_mid_update_cnt", dut.update_cnt_q, 32'd0);
    chk("rst_mid_mispredict_cnt", dut.mispredict_cnt_q, 32'd0);
    set_look(32'h180, 1'b0, 1'b0, 13'h0);
    cycle(1'b1, 1'b0, 32'h184, "rst_mid_lookup");

    // Randomized traffic over a small address pool to force hits and aliasing
    for (int n = 0; n < 3000; n++) begin
      set_look(32'h1000 + (32'($urandom_range(0, 3)) << 7) + (32'($urandom_range(0, 63)) << 1),
               1'($urandom), 1'($urandom), {12'($urandom), 1'b0});
      set_upd(1'($urandom), 32'h1000 + (32'($urandom_range(0, 3)) << 7) + (32'($urandom_range(0, 63)) << 1),
              $urandom, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 499) == 0) reset_mid();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
